// File: rtl/op_arb_pkg.sv
// Shared constants for the operand arbiter: FSM state encodings and
// width helpers for the requester index and the WAIT watchdog.
package op_arb_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_CLEAR = 3'd1;
  localparam logic [ST_W-1:0] ST_START = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
  localparam logic [ST_W-1:0] ST_RESP  = 3'd4;

  // Watchdog counts 0..TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/op_arbiter_rr_picker.sv
// Combinational round-robin selector: first requesting index strictly
// after ptr, wrapping from N-1 back to 0.
module rr_picker
  import op_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick_oh,
  output logic [IW-1:0] pick_idx,
  output logic          pick_vld
);

  logic [IW-1:0] cand;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    // k=N lands back on ptr itself, so the last-served index has lowest priority.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!pick_vld && req[cand]) begin
        pick_vld      = 1'b1;
        pick_oh[cand] = 1'b1;
        pick_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/op_arbiter.sv
// Round-robin arbiter sharing one multi-cycle arithmetic unit among N
// requesters, with stale-done rejection and a WAIT watchdog.
module op_arbiter
  import op_arb_pkg::*;
#(
  parameter int unsigned SIZE    = 16,
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*SIZE-1:0] a_in,
  input  logic [N*SIZE-1:0] b_in,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      res_valid,
  output logic [SIZE-1:0]   res_out,
  output logic              res_err,
  output logic              u_start,
  output logic              u_rst_begin,
  output logic [SIZE-1:0]   u_A,
  output logic [SIZE-1:0]   u_B,
  input  logic              u_done,
  input  logic [SIZE-1:0]   u_out
);

  localparam int unsigned IW = idx_width(N);
  localparam int unsigned WW = wd_width(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

  logic [ST_W-1:0] state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    res_valid_q, res_valid_d;
  logic [SIZE-1:0] res_out_q, res_out_d;
  logic            res_err_q, res_err_d;
  logic            u_start_q, u_start_d;
  logic            u_rst_begin_q, u_rst_begin_d;
  logic [SIZE-1:0] u_a_q, u_a_d;
  logic [SIZE-1:0] u_b_q, u_b_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic            done_prev_q, done_prev_d;

  logic [N-1:0]    pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [SIZE-1:0] sel_a, sel_b;
  logic            done_edge;
  logic            win_alive;

  rr_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .req      (req),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // Operand mux for the current round-robin winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pick_idx == IW'(i)) begin
        sel_a = a_in[i*SIZE +: SIZE];
        sel_b = b_in[i*SIZE +: SIZE];
      end
    end
  end

  // A done level carried over from the previous operation is not an edge.
  assign done_edge = u_done & ~done_prev_q;
  assign win_alive = |(req & gnt_q);

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    res_valid_d   = '0;
    res_out_d     = '0;
    res_err_d     = 1'b0;
    u_start_d     = 1'b0;
    u_rst_begin_d = 1'b0;
    u_a_d         = u_a_q;
    u_b_d         = u_b_q;
    wd_d          = wd_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    done_prev_d   = u_done;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d         = pick_idx;
          gnt_d         = pick_oh;
          u_a_d         = sel_a;
          u_b_d         = sel_b;
          u_rst_begin_d = 1'b1;
          state_d       = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        u_start_d = 1'b1;
        state_d   = ST_START;
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (done_edge) begin
          res_valid_d = win_alive ? gnt_q : '0;
          res_out_d   = win_alive ? u_out : '0;
          state_d     = ST_RESP;
        end else if (wd_q == WD_LAST) begin
          res_valid_d = win_alive ? gnt_q : '0;
          res_err_d   = win_alive;
          state_d     = ST_RESP;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      ST_RESP: begin
        ptr_d   = win_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      res_valid_q   <= '0;
      res_out_q     <= '0;
      res_err_q     <= 1'b0;
      u_start_q     <= 1'b0;
      u_rst_begin_q <= 1'b0;
      u_a_q         <= '0;
      u_b_q         <= '0;
      wd_q          <= '0;
      ptr_q         <= PTR_RST;
      win_q         <= '0;
      done_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      res_valid_q   <= res_valid_d;
      res_out_q     <= res_out_d;
      res_err_q     <= res_err_d;
      u_start_q     <= u_start_d;
      u_rst_begin_q <= u_rst_begin_d;
      u_a_q         <= u_a_d;
      u_b_q         <= u_b_d;
      wd_q          <= wd_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      done_prev_q   <= done_prev_d;
    end
  end

  assign gnt         = gnt_q;
  assign res_valid   = res_valid_q;
  assign res_out     = res_out_q;
  assign res_err     = res_err_q;
  assign u_start     = u_start_q;
  assign u_rst_begin = u_rst_begin_q;
  assign u_A         = u_a_q;
  assign u_B         = u_b_q;

endmodule

// File: doc/op_arbiter.md
OP_ARBITER -- requirements
Module: op_arbiter

Interface
REQ-001 Parameter SIZE, default 16, operand and result width in bits, matching the shared arithmetic unit.
REQ-002 Parameter N, default 4, number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 256, maximum WAIT cycles before an operation is aborted (>=4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  N  per-requester request level; held with operands until its res_valid, or dropped to abandon.
REQ-007 a_in  input  N*SIZE  operand A per requester, slice i = bits [i*SIZE +: SIZE].
REQ-008 b_in  input  N*SIZE  operand B per requester, same slicing.
REQ-009 gnt  output  N  one-hot grant, held from CLEAR through RESP; all-zero otherwise.
REQ-010 res_valid  output  N  one-cycle pulse on the bit of the served requester.
REQ-011 res_out  output  SIZE  result, valid only while any res_valid bit is high.
REQ-012 res_err  output  1  high with res_valid when the operation timed out.
REQ-013 u_start, u_rst_begin  output  1 each  start and pre-clear strobes to the shared unit.
REQ-014 u_A, u_B  output  SIZE each  registered operands to the unit, stable from CLEAR until the next grant.
REQ-015 u_done  input  1  unit completion flag; u_out  input  SIZE  unit result.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, START, WAIT, RESP.
- IDLE: if any req bit is high, latch the round-robin winner index and its operands into u_A/u_B, then go to CLEAR; else stay.
- CLEAR: u_rst_begin=1 for exactly one cycle, then go to START.
- START: u_start=1 for exactly one cycle, then go to WAIT with the watchdog cleared.
- WAIT: completion is a rising edge of u_done (high now, low previous cycle); a level held over from a prior operation SHALL NOT count. On completion, capture u_out and go to RESP with err=0. If the watchdog reaches TIMEOUT-1 first, go to RESP with err=1 and res_out=0.
- RESP: pulse res_valid[winner] for one cycle, advance the pointer to the winner, then go to IDLE.
REQ-017 Arbitration SHALL be round-robin: the winner is the first requesting index strictly after the last-served index, wrapping at N-1 to 0.
REQ-018 Latency from req rising in IDLE (cycle t) SHALL be: gnt and u_rst_begin at t+1, u_start at t+2, WAIT from t+3, res_valid one cycle after the u_done edge is sampled.
REQ-019 If the winner drops req before RESP, the operation SHALL run to completion or timeout, res_valid SHALL stay 0, and the pointer SHALL still advance.
REQ-020 Requests arriving in any state other than IDLE SHALL be held off and arbitrated only on the next IDLE cycle.
REQ-021 A u_done edge in the same cycle as the watchdog terminal count SHALL count as completion (err=0).
REQ-022 u_start and u_rst_begin SHALL never be high in the same cycle, and SHALL never be high outside CLEAR/START.

Reset
REQ-023 While rst is high: state=IDLE, gnt=0, res_valid=0, res_out=0, res_err=0, u_start=0, u_rst_begin=0, u_A=u_B=0, watchdog=0, pointer=N-1 (so index 0 has first priority).
REQ-024 Reset mid-operation SHALL abort immediately with no res_valid pulse; the bench resets the shared unit on the same rst.

Structure
REQ-025 Package op_arb_pkg SHALL hold the state enumeration and the watchdog width (clog2(TIMEOUT)).
REQ-026 The round-robin selector SHALL be a sub-module rr_picker (req, pointer -> one-hot and index, purely combinational).
REQ-027 Target implementation size is 150-300 lines.

Verification
REQ-028 Single request: req=0001, A=3, B=5; the unit model raises done 20 cycles after start with u_out=15 -> gnt=0001 at t+1, u_start at t+2, res_valid=0001 with res_out=15 and err=0.
REQ-029 Fairness: req=1111 held continuously -> grant order 0,1,2,3,0, with no gnt overlap and no gnt during IDLE.
REQ-030 Timeout: TIMEOUT=64, model never asserts done -> res_valid with res_err=1 and res_out=0 exactly 64 cycles after WAIT entry.
REQ-031 Stale done: u_done held high through CLEAR/START, then low for 3 cycles, then high -> completion only on the later edge.
REQ-032 Abandon: requester 2 drops req 5 cycles into WAIT -> no res_valid; the next grant goes to index 3 if it is requesting.
REQ-033 Reset pulse in WAIT -> all outputs 0 within the same cycle; after release, req=0010 is served first.
